// File: rtl/cla_adder_stage_if.sv
// ---------------------------------------------------------------------------
// cla_adder_stage_if
//   Bundles the operand/result handshake between a cla_adder_stage and its
//   environment, including the loop out to the combinational adder.
//   in_valid/in_ready/in_a/in_b : operand pair in
//   op_a/op_b                   : FIFO head presented to the adder
//   sum_in                      : N+1 bit adder result returned to the stage
//   out_valid/out_ready/out_sum : registered result out
//   slave  : the stage side
//   master : the environment side (producer, consumer, adder)
// ---------------------------------------------------------------------------
interface cla_adder_stage_if #(
  parameter int N = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N:0]   sum_in;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_sum;

  modport slave (
    input  in_valid, in_a, in_b, sum_in, out_ready,
    output in_ready, op_a, op_b, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, sum_in, out_ready,
    input  in_ready, op_a, op_b, out_valid, out_sum
  );
endinterface

// File: rtl/cla_adder_stage.sv
// ---------------------------------------------------------------------------
// cla_adder_stage
//   Handshaked wrapper around an external combinational N-bit CLA adder.
//   Operand pairs land in a 2-entry FIFO whose head drives op_a/op_b; the
//   adder's N+1 bit result is captured into a back-pressurable output
//   register. Results with carry-out set are counted (saturating).
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   flush       : synchronous clear of FIFO and output register
//   bus         : cla_adder_stage_if.slave (operands, adder loop, result)
//   carry_count : saturating count of captured results with bit N set
// ---------------------------------------------------------------------------
module cla_adder_stage #(
  parameter int N  = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cla_adder_stage_if.slave bus,
  output logic [CW-1:0] carry_count
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  occ_e          state_q, state_d;
  pair_t         head_q, head_d;
  pair_t         tail_q, tail_d;
  pair_t         in_pair;
  logic          out_valid_q;
  logic [N:0]    out_sum_q;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          load;

  assign in_pair = pair_t'({bus.in_a, bus.in_b});

  // in_ready is purely state-based: a pop in the same cycle never opens a
  // slot for a push while FULL.
  assign bus.in_ready = (state_q != FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign load         = (state_q != EMPTY) & (~out_valid_q | bus.out_ready);

  // head_q is the FIFO head and drives the adder directly, so the adder
  // input is registered and zero whenever the FIFO is empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_pair;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, load})
            2'b11: head_d = in_pair;  // pop and push: pushed pair is new head
            2'b01: begin
              head_d  = '0;
              state_d = EMPTY;
            end
            2'b10: begin
              tail_d  = in_pair;
              state_d = FULL;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (load) begin
            head_d  = tail_q;
            tail_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Output register: a load always wins over a drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= bus.sum_in;
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Carry events are taken from the value being captured, so a discarded
  // (flushed) load does not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (~flush & load & bus.sum_in[N] & (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.op_a      = head_q.a;
  assign bus.op_b      = head_q.b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign carry_count   = cnt_q;

endmodule
